lcd_spi_byte_tx: RTL and testbench

//  SPI byte transmitter for the ST7735 0.96" PMOD LCD. It sits directly downstream of the

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_spi_phase_timer.sv | 29 ++
 rtl/lcd_spi_byte_tx.sv | 166 ++++++++++++++++
 tb/tb_lcd_spi_byte_tx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the ST7735 PMOD LCD SPI path.
// State encoding, bus idle levels, default timing and opcodes used by the sequencers.
package lcd_pkg;

  // Byte transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_GAP   = 3'd4
  } lcd_state_e;

  // Bus idle levels (SPI mode 3: clock idles high, chip select inactive high)
  localparam logic SCL_IDLE = 1'b1;
  localparam logic CS_IDLE  = 1'b1;

  // Default timing
  localparam int DEF_CLK_DIV = 1;
  localparam int DEF_CS_GAP  = 2;

  // ST7735 opcodes
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_FRMCTR1 = 8'hB1;

  // Phase counter width: must hold the larger of the two reload values
  function automatic int timer_width(input int clk_div, input int cs_gap);
    int m;
    m = (clk_div > cs_gap) ? clk_div : cs_gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lcd_spi_phase_timer.sv
// lcd_spi_phase_timer: loadable down-counter. phase_done is high in the last cycle
// of a phase (count at zero while enabled); the FSM reloads it on every phase change.
module lcd_spi_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         phase_done
);

  logic [W-1:0] count_reg;

  // Reload on request, otherwise count down to zero and hold there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign phase_done = enable && (count_reg == '0);

endmodule

// File: rtl/lcd_spi_byte_tx.sv
// lcd_spi_byte_tx: SPI mode 3 byte transmitter for the ST7735 LCD (MSB first).
// Optional feature macro LCD_SPI_CS_BURST_EN: back-to-back bytes keep CS low,
// accepting the next byte in the last cycle of bit0 HIGH.
module lcd_spi_byte_tx
  import lcd_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int CS_GAP  = DEF_CS_GAP
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_DC,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       BUSY,
  output logic       SCL,
  output logic       MOSI,
  output logic       DC,
  output logic       CS
);

  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("lcd_spi_byte_tx: CLK_DIV must be >= 1");
  end
  if (CS_GAP < 1) begin : g_bad_cs_gap
    $error("lcd_spi_byte_tx: CS_GAP must be >= 1");
  end

  localparam int           TW       = timer_width(CLK_DIV, CS_GAP);
  localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(CS_GAP - 1);

  lcd_state_e  state_reg;
  logic [7:0]  shift_reg;     // MSB is the bit currently on MOSI
  logic [2:0]  bit_cnt_reg;   // 7 down to 0
  logic        scl_reg;
  logic        dc_reg;
  logic        cs_reg;
  logic        ready_reg;
  logic        busy_reg;

  logic        phase_done;
  logic        timer_enable;
  logic        timer_load;
  logic [TW-1:0] timer_val;
  logic        last_bit_end;
  logic        idle_take;
  logic        burst_take;

  assign last_bit_end = (state_reg == ST_HIGH) && (bit_cnt_reg == 3'd0) && phase_done;
  assign idle_take    = TX_VALID && ready_reg;   // ready_reg is only set in IDLE

`ifdef LCD_SPI_CS_BURST_EN
  assign TX_READY   = ready_reg | last_bit_end;
  assign burst_take = last_bit_end && TX_VALID;
`else
  assign TX_READY   = ready_reg;
  assign burst_take = 1'b0;
`endif

  assign BUSY = busy_reg;
  assign SCL  = scl_reg;
  assign MOSI = shift_reg[7];
  assign DC   = dc_reg;
  assign CS   = cs_reg;

  assign timer_enable = (state_reg != ST_IDLE);

  // Reload the phase timer on every phase change; only GAP uses the CS_GAP length
  always_comb begin
    timer_load = 1'b0;
    timer_val  = DIV_LOAD;
    if (idle_take || burst_take) begin
      timer_load = 1'b1;
    end else if (phase_done) begin
      case (state_reg)
        ST_SETUP, ST_LOW: timer_load = 1'b1;
        ST_HIGH: begin
          timer_load = 1'b1;
          if (bit_cnt_reg == 3'd0) timer_val = GAP_LOAD;
        end
        default: timer_load = 1'b0;
      endcase
    end
  end

  lcd_spi_phase_timer #(.W(TW)) u_timer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .enable     (timer_enable),
    .load       (timer_load),
    .load_val   (timer_val),
    .phase_done (phase_done)
  );

  // Byte FSM with registered bus outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= 8'h00;
      bit_cnt_reg <= 3'd0;
      scl_reg     <= SCL_IDLE;
      dc_reg      <= 1'b1;
      cs_reg      <= CS_IDLE;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (idle_take) begin
            state_reg   <= ST_SETUP;
            shift_reg   <= TX_DATA;
            dc_reg      <= TX_DC;
            bit_cnt_reg <= 3'd7;
            cs_reg      <= 1'b0;
            scl_reg     <= SCL_IDLE;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (phase_done) begin
            state_reg <= ST_LOW;
            scl_reg   <= 1'b0;
          end
        end
        ST_LOW: begin
          if (phase_done) begin
            state_reg <= ST_HIGH;
            scl_reg   <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (phase_done) begin
            if (bit_cnt_reg != 3'd0) begin
              bit_cnt_reg <= bit_cnt_reg - 3'd1;
              shift_reg   <= {shift_reg[6:0], 1'b0};
              scl_reg     <= 1'b0;
              state_reg   <= ST_LOW;
            end else if (burst_take) begin
              // Chain the next byte straight into its bit7 LOW phase, CS stays low
              shift_reg   <= TX_DATA;
              dc_reg      <= TX_DC;
              bit_cnt_reg <= 3'd7;
              scl_reg     <= 1'b0;
              state_reg   <= ST_LOW;
            end else begin
              cs_reg    <= CS_IDLE;
              state_reg <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (phase_done) begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_byte_tx.sv
// tb_lcd_spi_byte_tx: directed bench for lcd_spi_byte_tx, one instance at CLK_DIV=1
// and one at CLK_DIV=4. Expected values are hand-computed from the protocol timing.
module tb_lcd_spi_byte_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_dc = 1'b0;
  logic       valid1 = 1'b0;
  logic       valid4 = 1'b0;
  logic       ready1, busy1, scl1, mosi1, dc1, cs1;
  logic       ready4, busy4, scl4, mosi4, dc4, cs4;

  int n_cmp = 0;
  int n_err = 0;
  bit sel = 1'b0;

  logic o_scl, o_mosi, o_dc, o_cs, o_ready, o_busy;
  assign o_scl   = sel ? scl4   : scl1;
  assign o_mosi  = sel ? mosi4  : mosi1;
  assign o_dc    = sel ? dc4    : dc1;
  assign o_cs    = sel ? cs4    : cs1;
  assign o_ready = sel ? ready4 : ready1;
  assign o_busy  = sel ? busy4  : busy1;

  always #5 clk = ~clk;

  lcd_spi_byte_tx #(.CLK_DIV(1), .CS_GAP(2)) dut1 (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data), .TX_DC(tx_dc), .TX_VALID(valid1),
    .TX_READY(ready1), .BUSY(busy1), .SCL(scl1), .MOSI(mosi1), .DC(dc1), .CS(cs1)
  );

  lcd_spi_byte_tx #(.CLK_DIV(4), .CS_GAP(2)) dut4 (
    .CLK(clk), .RST_N(rst_n), .TX_DATA(tx_data), .TX_DC(tx_dc), .TX_VALID(valid4),
    .TX_READY(ready4), .BUSY(busy4), .SCL(scl4), .MOSI(mosi4), .DC(dc4), .CS(cs4)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Send one byte and watch it to completion (ready back in IDLE).
  // scramble: after acceptance, change TX_DATA/TX_DC and keep TX_VALID high until ready.
  task automatic run_byte(input bit s, input logic [7:0] data, input logic dcv, input bit scramble,
                          output logic [7:0] bits, output int rises, output int cs_low,
                          output int latency, output int busy_cyc, output bit dc_ok,
                          output int lo_min, output int lo_max);
    logic prev_scl;
    int   lo_run;
    sel = s;
    @(negedge clk);
    tx_data = data; tx_dc = dcv;
    if (s) valid4 = 1'b1; else valid1 = 1'b1;
    prev_scl = o_scl;
    @(posedge clk); #1;
    if (scramble) begin
      tx_data = 8'hFF; tx_dc = ~dcv;
    end else begin
      valid1 = 1'b0; valid4 = 1'b0;
    end
    bits = 8'h00; rises = 0; cs_low = 0; latency = -1; busy_cyc = 0; dc_ok = 1'b1;
    lo_min = 1000; lo_max = 0; lo_run = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (o_scl && !prev_scl) begin
        bits = {bits[6:0], o_mosi};
        rises++;
      end
      if (!o_scl) lo_run++;
      else if (lo_run > 0) begin
        if (lo_run < lo_min) lo_min = lo_run;
        if (lo_run > lo_max) lo_max = lo_run;
        lo_run = 0;
      end
      if (!o_cs) begin
        cs_low++;
        if (o_dc !== dcv) dc_ok = 1'b0;
      end
      if (o_busy) busy_cyc++;
      prev_scl = o_scl;
      if (o_ready) begin
        valid1 = 1'b0; valid4 = 1'b0;
      end
      if (o_ready && !o_busy) begin
        latency = n - 1;
        break;
      end
    end
    $display("tx dut%0d byte=%02h dc=%0b -> sampled=%02h rises=%0d cs_low=%0d latency=%0d",
             s ? 4 : 1, data, dcv, bits, rises, cs_low, latency);
  endtask

  logic [7:0]  bits;
  int          rises, cs_low, latency, busy_cyc, lo_min, lo_max;
  bit          dc_ok;
  logic [7:0]  stream_bytes [4] = '{8'hB1, 8'h05, 8'h3C, 8'h3C};
  logic        stream_dcs   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    // 1: asynchronous reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_vec_div1", {26'd0, scl1, cs1, dc1, mosi1, ready1, busy1}, 32'b111010);
    check_val("rst_vec_div4", {26'd0, scl4, cs4, dc4, mosi4, ready4, busy4}, 32'b111010);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 2: CLK_DIV=1, FRMCTR1 command
    run_byte(1'b0, 8'hB1, 1'b0, 1'b0, bits, rises, cs_low, latency, busy_cyc, dc_ok, lo_min, lo_max);
    check_val("b1_bits", bits, 8'hB1);
    check_val("b1_rises", rises, 8);
    check_val("b1_cs_low", cs_low, 17);
    check_val("b1_latency", latency, 19);
    check_val("b1_dc_stable", dc_ok, 1);
    check_val("b1_busy_cyc", busy_cyc, 19);
    check_val("b1_scl_low_min", lo_min, 1);
    check_val("b1_scl_low_max", lo_max, 1);

    // 3: CLK_DIV=4, data byte
    run_byte(1'b1, 8'h3C, 1'b1, 1'b0, bits, rises, cs_low, latency, busy_cyc, dc_ok, lo_min, lo_max);
    check_val("d4_bits", bits, 8'h3C);
    check_val("d4_rises", rises, 8);
    check_val("d4_cs_low", cs_low, 68);
    check_val("d4_latency", latency, 70);
    check_val("d4_dc_stable", dc_ok, 1);
    check_val("d4_scl_low_min", lo_min, 4);
    check_val("d4_scl_low_max", lo_max, 4);

    // 4: stream of four bytes with TX_VALID held
    begin
      int   idx, windows, srises, gap_run, n_gaps;
      bit   gaps_ok, done, acc;
      logic prev_scl, prev_cs;
      logic [31:0] bits32, dc32;
      sel = 1'b0;
      @(negedge clk);
      idx = 0; tx_data = stream_bytes[0]; tx_dc = stream_dcs[0]; valid1 = 1'b1;
      prev_scl = scl1; prev_cs = cs1;
      windows = 0; srises = 0; gap_run = 0; n_gaps = 0; gaps_ok = 1'b1; done = 1'b0;
      bits32 = '0; dc32 = '0;
      for (int n = 0; n < 600 && !done; n++) begin
        if (!cs1 && prev_cs) begin
          windows++;
          if (windows > 1) begin
            n_gaps++;
            // GAP (2 cycles) plus the IDLE cycle in which the next byte is accepted
            if (gap_run != 3) gaps_ok = 1'b0;
          end
          gap_run = 0;
        end
        if (cs1) gap_run++;
        if (scl1 && !prev_scl && !cs1) begin
          srises++;
          bits32 = {bits32[30:0], mosi1};
          dc32   = {dc32[30:0], dc1};
        end
        prev_scl = scl1; prev_cs = cs1;
        if (idx == 4 && ready1 && !busy1) begin
          done = 1'b1;
        end else begin
          acc = valid1 && ready1;
          @(posedge clk); #1;
          if (acc) begin
            idx++;
            if (idx < 4) begin
              tx_data = stream_bytes[idx]; tx_dc = stream_dcs[idx];
            end else begin
              valid1 = 1'b0;
            end
          end
          @(negedge clk);
        end
      end
      $display("tx stream bytes=%0d windows=%0d rises=%0d data=%08h dc=%08h",
               idx, windows, srises, bits32, dc32);
      check_val("st_done", done, 1);
      check_val("st_rises", srises, 32);
      check_val("st_bits", bits32, 32'hB1053C3C);
      check_val("st_dc", dc32, 32'h00FFFFFF);
`ifdef LCD_SPI_CS_BURST_EN
      check_val("st_windows", windows, 1);
      check_val("st_n_gaps", n_gaps, 0);
`else
      check_val("st_windows", windows, 4);
      check_val("st_n_gaps", n_gaps, 3);
      check_val("st_gap_len", gaps_ok, 1);
`endif
    end

    // 5: reset pulse after the 3rd SCL rise of 8'hB1
    begin
      logic prev_scl;
      int   r;
      sel = 1'b0;
      @(negedge clk);
      tx_data = 8'hB1; tx_dc = 1'b0; valid1 = 1'b1;
      prev_scl = scl1;
      @(posedge clk); #1;
      valid1 = 1'b0;
      r = 0;
      for (int n = 0; n < 50 && r < 3; n++) begin
        @(negedge clk);
        if (scl1 && !prev_scl) r++;
        prev_scl = scl1;
      end
      check_val("rs_rises_before", r, 3);
      #1 rst_n = 1'b0;
      #1;
      $display("tx reset pulse after %0d rises", r);
      check_val("rs_vec", {26'd0, scl1, cs1, dc1, mosi1, ready1, busy1}, 32'b111010);
      @(negedge clk); @(negedge clk);
      check_val("rs_vec_held", {26'd0, scl1, cs1, dc1, mosi1, ready1, busy1}, 32'b111010);
      rst_n = 1'b1;
    end
    run_byte(1'b0, 8'h05, 1'b1, 1'b0, bits, rises, cs_low, latency, busy_cyc, dc_ok, lo_min, lo_max);
    check_val("rs_05_bits", bits, 8'h05);
    check_val("rs_05_rises", rises, 8);
    check_val("rs_05_latency", latency, 19);
    check_val("rs_05_dc_stable", dc_ok, 1);

    // 6: inputs change while busy; the latched byte and flag must be unaffected
    run_byte(1'b0, 8'hA5, 1'b0, 1'b1, bits, rises, cs_low, latency, busy_cyc, dc_ok, lo_min, lo_max);
    check_val("hold_bits", bits, 8'hA5);
    check_val("hold_dc_stable", dc_ok, 1);
    check_val("hold_busy_cyc", busy_cyc, 19);
    check_val("hold_latency", latency, 19);
    @(negedge clk);
    check_val("hold_no_reaccept", {30'd0, busy1, cs1}, 32'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
